mlx90640_frame_capture: RTL and testbench

Downstream consumer of the MLX90640 RAM burst. The controller issues the 832-word RAM read and leaves those words in the shared read-data FIFO; this block pops them. It de-interleaves the words by subpage into a 768-pixel frame-buffer write port and a 64-word auxiliary write port, then flags frame completion. It sits between the I2C read-data FIFO and the frame buffer / temperature-calculation stages.

---
 rtl/mlx90640_frame_capture.sv | 134 +++++++++++++
 tb/tb_mlx90640_frame_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mlx90640_frame_capture.sv
// Pops one MLX90640 RAM burst from the read FIFO and splits it into subpage-filtered
// pixel writes and unconditional aux writes, pulsing frame_done once the burst is consumed.
module mlx90640_frame_capture #(
  parameter int p_cols       = 32,
  parameter int p_rows       = 24,
  parameter int p_aux_words  = 64,
  parameter bit p_chess_mode = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arm,
  input  logic        i_page_number,
  input  logic        i_rd_fifo_valid,
  input  logic [15:0] i_rd_fifo_data,
  output logic        o_rd_fifo_ready,
  output logic        o_pix_we,
  output logic [9:0]  o_pix_addr,
  output logic [15:0] o_pix_data,
  output logic        o_aux_we,
  output logic [5:0]  o_aux_addr,
  output logic [15:0] o_aux_data,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_frame_page,
  output logic        o_overrun
);

  typedef enum logic [1:0] {IDLE, PIXEL, AUX, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  row_reg, col_reg;
  logic [5:0]  aux_reg;
  logic        page_reg, overrun_reg;
  logic        pix_we_reg, aux_we_reg;
  logic [9:0]  pix_addr_reg;
  logic [15:0] pix_data_reg, aux_data_reg;
  logic [5:0]  aux_addr_reg;

  logic       pop, last_pix, last_aux, col_wrap, pix_match;
  logic [9:0] pix_addr_calc;

  assign o_rd_fifo_ready = (state_reg == PIXEL) || (state_reg == AUX);
  assign pop             = o_rd_fifo_ready && i_rd_fifo_valid;
  assign col_wrap        = (col_reg == 5'(p_cols - 1));
  assign last_pix        = col_wrap && (row_reg == 5'(p_rows - 1));
  assign last_aux        = (aux_reg == 6'(p_aux_words - 1));
  assign pix_addr_calc   = 10'(int'(row_reg) * p_cols + int'(col_reg));

  // Subpage of the word currently at the head of the FIFO
  assign pix_match = p_chess_mode ? ((row_reg[0] ^ col_reg[0]) == page_reg)
                                  : (row_reg[0] == page_reg);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_arm) state_next = PIXEL;
      PIXEL:   if (pop && last_pix) state_next = AUX;
      AUX:     if (pop && last_aux) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_reg      <= '0;
      col_reg      <= '0;
      aux_reg      <= '0;
      page_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      pix_we_reg   <= 1'b0;
      pix_addr_reg <= '0;
      pix_data_reg <= '0;
      aux_we_reg   <= 1'b0;
      aux_addr_reg <= '0;
      aux_data_reg <= '0;
    end else begin
      pix_we_reg <= 1'b0;
      aux_we_reg <= 1'b0;
      if (i_arm && state_reg != IDLE) overrun_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (i_arm) begin
            page_reg <= i_page_number;
            row_reg  <= '0;
            col_reg  <= '0;
            aux_reg  <= '0;
          end
        end
        PIXEL: begin
          if (pop) begin
            if (pix_match) begin
              pix_we_reg   <= 1'b1;
              pix_addr_reg <= pix_addr_calc;
              pix_data_reg <= i_rd_fifo_data;
            end
            if (col_wrap) begin
              col_reg <= '0;
              row_reg <= row_reg + 5'd1;
            end else begin
              col_reg <= col_reg + 5'd1;
            end
          end
        end
        AUX: begin
          if (pop) begin
            aux_we_reg   <= 1'b1;
            aux_addr_reg <= aux_reg;
            aux_data_reg <= i_rd_fifo_data;
            aux_reg      <= aux_reg + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pix_we     = pix_we_reg;
  assign o_pix_addr   = pix_addr_reg;
  assign o_pix_data   = pix_data_reg;
  assign o_aux_we     = aux_we_reg;
  assign o_aux_addr   = aux_addr_reg;
  assign o_aux_data   = aux_data_reg;
  assign o_busy       = o_rd_fifo_ready;
  assign o_frame_done = (state_reg == DONE);
  assign o_frame_page = page_reg;
  assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_mlx90640_frame_capture.sv
// Drives chess and interleaved instances with the same bursts and compares their
// write streams against lists derived from the frame layout rules.
module tb_mlx90640_frame_capture;

  logic        clk = 1'b0;
  logic        rst, arm, page, valid;
  logic [15:0] data;

  logic        c_ready, c_pix_we, c_aux_we, c_busy, c_done, c_page, c_ovr;
  logic [9:0]  c_pix_addr;
  logic [15:0] c_pix_data, c_aux_data;
  logic [5:0]  c_aux_addr;
  logic        i_ready, i_pix_we, i_aux_we, i_busy, i_done, i_page, i_ovr;
  logic [9:0]  i_pix_addr;
  logic [15:0] i_pix_data, i_aux_data;
  logic [5:0]  i_aux_addr;

  int n_pass = 0;
  int n_total = 0;
  int done_c, done_i;
  logic exp_ovr;
  logic [15:0] w [832];
  logic [25:0] pix_q_c[$], pix_q_i[$], aux_q_c[$], aux_q_i[$];

  initial forever #5 clk = ~clk;

  mlx90640_frame_capture #(.p_chess_mode(1'b1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_page_number(page),
    .i_rd_fifo_valid(valid), .i_rd_fifo_data(data), .o_rd_fifo_ready(c_ready),
    .o_pix_we(c_pix_we), .o_pix_addr(c_pix_addr), .o_pix_data(c_pix_data),
    .o_aux_we(c_aux_we), .o_aux_addr(c_aux_addr), .o_aux_data(c_aux_data),
    .o_busy(c_busy), .o_frame_done(c_done), .o_frame_page(c_page), .o_overrun(c_ovr));

  mlx90640_frame_capture #(.p_chess_mode(1'b0)) dut_i (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_page_number(page),
    .i_rd_fifo_valid(valid), .i_rd_fifo_data(data), .o_rd_fifo_ready(i_ready),
    .o_pix_we(i_pix_we), .o_pix_addr(i_pix_addr), .o_pix_data(i_pix_data),
    .o_aux_we(i_aux_we), .o_aux_addr(i_aux_addr), .o_aux_data(i_aux_data),
    .o_busy(i_busy), .o_frame_done(i_done), .o_frame_page(i_page), .o_overrun(i_ovr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write collector; frame_done must coincide with the final aux write
  always @(negedge clk) begin
    if (c_pix_we) pix_q_c.push_back({c_pix_addr, c_pix_data});
    if (i_pix_we) pix_q_i.push_back({i_pix_addr, i_pix_data});
    if (c_aux_we) aux_q_c.push_back({4'b0, c_aux_addr, c_aux_data});
    if (i_aux_we) aux_q_i.push_back({4'b0, i_aux_addr, i_aux_data});
    if (c_done) begin
      done_c++;
      chk("done_aux_we_c", 32'(c_aux_we), 1);
      chk("done_aux_addr_c", 32'(c_aux_addr), 63);
      chk("done_busy_c", 32'(c_busy), 0);
    end
    if (i_done) begin
      done_i++;
      chk("done_aux_we_i", 32'(i_aux_we), 1);
      chk("done_aux_addr_i", 32'(i_aux_addr), 63);
    end
  end

  task automatic cmp_q(input string tag, input logic [25:0] got[$], input logic [25:0] exp[$]);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      chk(tag, 32'(got[k]), 32'(exp[k]));
  endtask

  // Reference: walk the frame in raster order and keep words whose subpage matches
  task automatic check_lists(input logic pg);
    logic [25:0] ec[$], ei[$], ea[$];
    for (int a = 0; a < 768; a++) begin
      int r = a / 32;
      int c = a % 32;
      if (((r ^ c) & 1) == int'(pg)) ec.push_back({10'(a), w[a]});
      if ((r & 1) == int'(pg)) ei.push_back({10'(a), w[a]});
    end
    for (int k = 0; k < 64; k++) ea.push_back({4'b0, 6'(k), w[768 + k]});
    cmp_q("pix_chess", pix_q_c, ec);
    cmp_q("pix_inter", pix_q_i, ei);
    cmp_q("aux_chess", aux_q_c, ea);
    cmp_q("aux_inter", aux_q_i, ea);
    $display("burst page=%0d: chess pix=%0d inter pix=%0d aux=%0d done=%0d/%0d",
             pg, pix_q_c.size(), pix_q_i.size(), aux_q_c.size(), done_c, done_i);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'({c_ready, i_ready}), 0);
    chk({tag, "_we"}, 32'({c_pix_we, c_aux_we, i_pix_we, i_aux_we}), 0);
    chk({tag, "_busy"}, 32'({c_busy, i_busy}), 0);
    chk({tag, "_done"}, 32'({c_done, i_done}), 0);
    chk({tag, "_page"}, 32'({c_page, i_page}), 0);
    chk({tag, "_ovr"}, 32'({c_ovr, i_ovr}), 0);
  endtask

  // mode 0: continuous; 1: valid toggling plus a 20-cycle gap; 2: stray arms at pop 100 and in DONE
  task automatic run_burst(input logic pg, input int mode, input int rst_at);
    int idx = 0;
    int cyc = 0;
    bit gap, prev_gap = 0;
    pix_q_c.delete(); pix_q_i.delete(); aux_q_c.delete(); aux_q_i.delete();
    done_c = 0; done_i = 0;
    @(posedge clk); #1;
    arm = 1'b1; page = pg;
    @(posedge clk); #1;
    arm = 1'b0;
    while (idx < 832) begin
      if (rst_at >= 0 && idx == rst_at) begin
        valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_ovr = 1'b0;
        @(negedge clk);
        check_idle_zero("after_rst");
        $display("reset applied after %0d pops", idx);
        return;
      end
      gap = (mode == 1) && ((cyc % 2 == 1) || (cyc >= 300 && cyc < 320));
      valid = !gap;
      data = w[idx];
      arm = (mode == 2) && (idx == 100) && !gap;
      @(negedge clk);
      chk("ready_in_burst", 32'({c_ready, i_ready}), 3);
      chk("busy_in_burst", 32'({c_busy, i_busy}), 3);
      if (gap && prev_gap)
        chk("we_in_gap", 32'({c_pix_we, c_aux_we, i_pix_we, i_aux_we}), 0);
      @(posedge clk); #1;
      arm = 1'b0;
      if (!gap) idx++;
      prev_gap = gap;
      cyc++;
    end
    valid = 1'b0;
    if (mode == 2) begin
      arm = 1'b1;
      exp_ovr = 1'b1;
    end
    @(posedge clk); #1;
    arm = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_ready", 32'({c_ready, i_ready}), 0);
    chk("end_busy", 32'({c_busy, i_busy}), 0);
    chk("done_count_c", 32'(done_c), 1);
    chk("done_count_i", 32'(done_i), 1);
    chk("frame_page", 32'({c_page, i_page}), {30'b0, pg, pg});
    chk("overrun", 32'({c_ovr, i_ovr}), {30'b0, exp_ovr, exp_ovr});
    check_lists(pg);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; page = 1'b0; valid = 1'b0; data = '0; exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 832; k++) w[k] = 16'(k);
    run_burst(1'b0, 0, -1);

    for (int k = 0; k < 832; k++) w[k] = 16'($urandom);
    run_burst(1'b1, 0, -1);

    for (int k = 0; k < 832; k++) w[k] = 16'($urandom);
    run_burst(1'b0, 1, -1);

    for (int k = 0; k < 832; k++) w[k] = 16'($urandom);
    run_burst(1'b1, 2, -1);

    for (int k = 0; k < 832; k++) w[k] = 16'($urandom);
    run_burst(1'b0, 0, 400);

    for (int k = 0; k < 832; k++) w[k] = 16'(k);
    run_burst(1'b0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
